// File: rtl/mu0_sequencer.sv
// ---------------------------------------------------------------------------
// mu0_sequencer
//
// Control sequencer for the MU0 CPU. It sits directly upstream of the
// instruction decoder and does four jobs:
//   - holds the instruction register
//   - steps through the FETCH / EXEC1 / EXEC2 timing states
//   - tracks the conditional-skip flag set by SKP and stops the core on STP
//   - supports run/single-step control, with cycle and instruction counters
//     for debug
//
// Ports
//   CLK         system clock, rising edge
//   RESET_N     synchronous, active-low reset
//   RUN         1 = free-run, 0 = stop at the next instruction boundary
//   STEP        in IDLE, start exactly one instruction
//   IR_NEXT     memory data bus, captured into IR during FETCH
//   EXTRA       from decode; sampled in EXEC1, 1 = an EXEC2 cycle is needed
//   EQ, MI      accumulator zero / negative flags, used as SKP conditions
//   FETCH, EXEC1, EXEC2, IDLE, HALTED
//               registered one-hot decodes of the sequencer state
//   IR          instruction register, to decode
//   skipstatus  the current instruction is being skipped
//   CYCLES      count of FETCH/EXEC1/EXEC2 cycles (wraps)
//   INSTRS      count of completed instructions, including STP (wraps)
// ---------------------------------------------------------------------------
module mu0_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUN,
  input  logic             STEP,
  input  logic [15:0]      IR_NEXT,
  input  logic             EXTRA,
  input  logic             EQ,
  input  logic             MI,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [15:0]      IR,
  output logic             skipstatus,
  output logic             HALTED,
  output logic             IDLE,
  output logic [CNT_W-1:0] CYCLES,
  output logic [CNT_W-1:0] INSTRS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_SKP = 4'b1001;

  state_t state;
  state_t state_next;

  // A SKP whose condition held in EXEC1 but which went on to EXEC2. The flag
  // must not rise until SKP's own boundary, so the result is parked here.
  logic skip_arm;

  logic skp_cond;
  logic skp_fires;
  logic stp_halts;
  logic boundary;
  logic instr_done;

  // NOTE: every signal assigned in always_comb gets a default first, so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    skp_cond   = 1'b0;
    state_next = state;

    unique case (IR[1:0])
      2'b00: skp_cond = 1'b1;
      2'b01: skp_cond = EQ;
      2'b10: skp_cond = MI;
      2'b11: skp_cond = !EQ;
    endcase

    // A skipped SKP cannot set the flag, and a skipped STP does not halt.
    skp_fires = (IR[15:12] == OP_SKP) && skp_cond && !skipstatus;
    stp_halts = (IR[15:12] == OP_STP) && !skipstatus;

    boundary   = ((state == S_EXEC1) && !stp_halts && !EXTRA) ||
                 (state == S_EXEC2);
    // STP counts as a completed instruction when it enters HALT.
    instr_done = boundary || ((state == S_EXEC1) && stp_halts);

    unique case (state)
      S_IDLE:  if (RUN || STEP) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC1;
      S_EXEC1: begin
        if (stp_halts)  state_next = S_HALT;
        else if (EXTRA) state_next = S_EXEC2;
      end
      S_EXEC2: state_next = S_EXEC2;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase

    if (boundary) state_next = RUN ? S_FETCH : S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      IDLE       <= 1'b1;
      FETCH      <= 1'b0;
      EXEC1      <= 1'b0;
      EXEC2      <= 1'b0;
      HALTED     <= 1'b0;
      IR         <= 16'h0000;
      skipstatus <= 1'b0;
      skip_arm   <= 1'b0;
      CYCLES     <= '0;
      INSTRS     <= '0;
    end else begin
      state  <= state_next;
      // Decode from the next state so each output flop matches the state
      // register in the same cycle.
      IDLE   <= (state_next == S_IDLE);
      FETCH  <= (state_next == S_FETCH);
      EXEC1  <= (state_next == S_EXEC1);
      EXEC2  <= (state_next == S_EXEC2);
      HALTED <= (state_next == S_HALT);

      if (state == S_FETCH) IR <= IR_NEXT;

      if (state == S_FETCH || state == S_EXEC1 || state == S_EXEC2)
        CYCLES <= CYCLES + CNT_W'(1);

      if (instr_done) INSTRS <= INSTRS + CNT_W'(1);

      if (state == S_EXEC1) skip_arm <= skp_fires;

      // At a boundary a set flag has served its one instruction and drops.
      // A clear flag rises only when this instruction was a firing SKP.
      if (boundary)
        skipstatus <= !skipstatus &&
                      ((state == S_EXEC1) ? skp_fires : skip_arm);
    end
  end

endmodule
